perf_event_monitor: RTL and testbench

- Synthesizable, parametrised performance-monitor block that sits beside the processor core and counts pipeline events in hardware.
- Events counted: cycles, retired instructions, and NUM_EVT generic event pulses such as I/D cache request and hit.
- On halt it freezes all counters and streams them out over a valid/ready port, so benches and on-chip debug logic read identical statistics.
- Supports selectable saturate/wrap counting, sticky overflow flags, random-access readback and software clear.

---
 rtl/perf_event_monitor_if.sv | 32 +++
 rtl/perf_event_monitor.sv | 122 ++++++++++++
 tb/tb_perf_event_monitor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_event_monitor_if.sv
// perf_event_monitor_if: dump stream port (valid/ready word stream plus completion flag).
// Revision 1.0
`default_nettype none

interface perf_event_monitor_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 32
) ();
  logic             dump_valid;
  logic             dump_ready;
  logic [IDX_W-1:0] dump_idx;
  logic [CNT_W-1:0] dump_data;
  logic             done;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output done,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  done,
    output dump_ready
  );
endinterface

`default_nettype wire

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: cycle/retire/event counters, frozen on halt and streamed out over a valid/ready port.
// Revision 1.0
`default_nettype none

module perf_event_monitor #(
  parameter  int NUM_EVT  = 4,
  parameter  int CNT_W    = 32,
  parameter  int SATURATE = 1,
  localparam int NCNT     = NUM_EVT + 2,
  localparam int IDX_W    = $clog2(NCNT)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               en,
  input  wire logic               clr,
  input  wire logic               retire,
  input  wire logic               halt,
  input  wire logic [NUM_EVT-1:0] evt,
  input  wire logic [IDX_W-1:0]   rd_idx,
  output logic      [CNT_W-1:0]   rd_data,
  output logic      [NCNT-1:0]    ovf,
  perf_event_monitor_if.master    dump_if
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCNT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]  ovf_q, ovf_d;
  logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] dump_mux;
  logic [NCNT-1:0]  inc;

  // Counter 0 always ticks; a halting instruction also retires.
  assign inc = {evt, retire | halt, 1'b1};

  always_comb begin
    state_d    = state_q;
    dump_idx_d = dump_idx_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    if (clr) begin
      state_d    = ST_RUN;
      dump_idx_d = '0;
      ovf_d      = '0;
      for (int i = 0; i < NCNT; i++) cnt_d[i] = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en) begin
            for (int i = 0; i < NCNT; i++) begin
              if (inc[i]) begin
                if (cnt_q[i] == ALL_ONES) begin
                  ovf_d[i] = 1'b1;
                  cnt_d[i] = (SATURATE != 0) ? ALL_ONES : '0;
                end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
              end
            end
            if (halt) state_d = ST_DUMP;
          end
        end
        ST_DUMP: begin
          // The last index is held rather than advanced so it never wraps past NCNT-1.
          if (dump_if.dump_ready) begin
            if (dump_idx_q == LAST_IDX) state_d = ST_DONE;
            else                        dump_idx_d = dump_idx_q + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Out-of-range read indices fall through to zero.
  always_comb begin
    rd_data_d = '0;
    dump_mux  = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_idx == IDX_W'(i))     rd_data_d = cnt_q[i];
      if (dump_idx_q == IDX_W'(i)) dump_mux  = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      dump_idx_q <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      dump_idx_q <= dump_idx_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_data            = rd_data_q;
  assign ovf                = ovf_q;
  assign dump_if.dump_valid = (state_q == ST_DUMP);
  assign dump_if.done       = (state_q == ST_DONE);
  assign dump_if.dump_idx   = dump_idx_q;
  assign dump_if.dump_data  = dump_mux;

endmodule

`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
// tb_perf_event_monitor: directed bench with a scoreboard queue for readback and dump words.
// Revision 1.0
`default_nettype none

module tb_perf_event_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, clr = 1'b0, retire = 1'b0, halt = 1'b0;
  logic [3:0]  evt = 4'h0;
  logic [2:0]  rd_idx = 3'd0;
  logic [31:0] rd_data;
  logic [5:0]  ovf;

  logic        en8 = 1'b0;
  logic [2:0]  rd_idx8 = 3'd0;
  logic [7:0]  rd_s, rd_w;
  logic [5:0]  ovf_s, ovf_w;

  perf_event_monitor_if #(.IDX_W(3), .CNT_W(32)) dif ();
  perf_event_monitor_if #(.IDX_W(3), .CNT_W(8))  ds ();
  perf_event_monitor_if #(.IDX_W(3), .CNT_W(8))  dw ();

  assign ds.dump_ready = 1'b0;
  assign dw.dump_ready = 1'b0;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(32), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .retire(retire), .halt(halt),
    .evt(evt), .rd_idx(rd_idx), .rd_data(rd_data), .ovf(ovf), .dump_if(dif)
  );

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en8), .clr(1'b0), .retire(1'b0), .halt(1'b0),
    .evt(4'h0), .rd_idx(rd_idx8), .rd_data(rd_s), .ovf(ovf_s), .dump_if(ds)
  );

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en8), .clr(1'b0), .retire(1'b0), .halt(1'b0),
    .evt(4'h0), .rd_idx(rd_idx8), .rd_data(rd_w), .ovf(ovf_w), .dump_if(dw)
  );

  typedef struct {
    logic [63:0] idx;
    logic [63:0] data;
  } exp_t;

  exp_t           sbq[$];
  longint unsigned m_cnt[6];
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic r, input logic h, input logic [3:0] ev);
    en = e; retire = r; halt = h; evt = ev;
  endtask

  // Applies one cycle of stimulus; the model only advances when the monitor is counting.
  task automatic count_cycle(input logic e, input logic r, input logic h, input logic [3:0] ev);
    drive(e, r, h, ev);
    step();
    if (e) begin
      m_cnt[0]++;
      if (r | h) m_cnt[1]++;
      for (int k = 0; k < 4; k++) if (ev[k]) m_cnt[k+2]++;
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_all();
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    step();
    clr = 1'b0;
    model_zero();
  endtask

  task automatic read_chk(input int idx);
    exp_t e;
    rd_idx = 3'(idx);
    e.idx  = 64'(idx);
    e.data = (idx < 6) ? m_cnt[idx] : 64'd0;
    sbq.push_back(e);
    step();
    e = sbq.pop_front();
    chk($sformatf("rd_idx%0d", e.idx), {32'd0, rd_data}, e.data);
  endtask

  task automatic read_all();
    for (int i = 0; i < 6; i++) read_chk(i);
  endtask

  // Drains a dump, withholding ready for stall_len cycles once stall_at words have been taken.
  task automatic dump_all(input int stall_at, input int stall_len);
    exp_t e;
    int   taken = 0;
    int   stalled = 0;
    int   budget = 0;
    logic rdy;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      e.idx  = 64'(i);
      e.data = m_cnt[i];
      sbq.push_back(e);
    end
    while (sbq.size() > 0 && budget < 40) begin
      chk("dump_valid", {63'd0, dif.dump_valid}, 64'd1);
      chk("dump_idx", {61'd0, dif.dump_idx}, sbq[0].idx);
      chk($sformatf("dump_data%0d", sbq[0].idx), {32'd0, dif.dump_data}, sbq[0].data);
      rdy = !(taken >= stall_at && stalled < stall_len);
      if (rdy) begin
        e = sbq.pop_front();
        taken++;
      end else begin
        stalled++;
      end
      dif.dump_ready = rdy;
      step();
      budget++;
    end
    chk("dump_words_left", 64'(sbq.size()), 64'd0);
    sbq.delete();
    chk("done_after_dump", {63'd0, dif.done}, 64'd1);
    chk("valid_after_dump", {63'd0, dif.dump_valid}, 64'd0);
    dif.dump_ready = 1'b0;
  endtask

  initial begin
    dif.dump_ready = 1'b0;
    model_zero();

    // Reset state
    step();
    step();
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_dump_valid", {63'd0, dif.dump_valid}, 64'd0);
    chk("rst_done", {63'd0, dif.done}, 64'd0);
    chk("rst_ovf", {58'd0, ovf}, 64'd0);
    chk("rst_dump_idx", {61'd0, dif.dump_idx}, 64'd0);
    rst = 1'b1;

    // Ten retiring cycles, evt[0] on three of them
    for (int i = 0; i < 10; i++)
      count_cycle(1'b1, 1'b1, 1'b0, (i == 1 || i == 4 || i == 8) ? 4'b0001 : 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    read_chk(0);
    read_chk(1);
    read_chk(2);
    read_chk(7);
    chk("ovf_after_count", {58'd0, ovf}, 64'd0);

    // Disabled cycles with activity, and a halt while disabled
    for (int i = 0; i < 5; i++) count_cycle(1'b0, 1'b1, 1'b0, 4'(i + 5));
    count_cycle(1'b0, 1'b0, 1'b1, 4'hF);
    chk("halt_en0_valid", {63'd0, dif.dump_valid}, 64'd0);
    count_cycle(1'b0, 1'b0, 1'b0, 4'h0);
    chk("halt_en0_valid2", {63'd0, dif.dump_valid}, 64'd0);
    chk("halt_en0_done", {63'd0, dif.done}, 64'd0);
    read_all();

    // Seven counted cycles ending in halt, continuous ready
    clear_all();
    for (int i = 0; i < 7; i++)
      count_cycle(1'b1, (i % 2) == 0, i == 6, 4'($urandom_range(0, 15)));
    dump_all(99, 0);

    // Dump with ready withheld for four cycles after two words
    clear_all();
    for (int i = 0; i < 5; i++)
      count_cycle(1'b1, i != 2, i == 4, 4'($urandom_range(0, 15)));
    dump_all(2, 4);
    read_all();

    // clr overlapping halt and events
    clear_all();
    for (int i = 0; i < 3; i++) count_cycle(1'b1, 1'b1, 1'b0, 4'hF);
    clr = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'hF);
    step();
    clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    model_zero();
    chk("clr_halt_valid", {63'd0, dif.dump_valid}, 64'd0);
    step();
    chk("clr_halt_valid2", {63'd0, dif.dump_valid}, 64'd0);
    chk("clr_halt_done", {63'd0, dif.done}, 64'd0);
    read_all();
    chk("clr_ovf", {58'd0, ovf}, 64'd0);

    // Asynchronous reset in the middle of a dump
    for (int i = 0; i < 4; i++) count_cycle(1'b1, 1'b1, i == 3, 4'h3);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    dif.dump_ready = 1'b1;
    step();
    dif.dump_ready = 1'b0;
    step();
    chk("pre_rst_valid", {63'd0, dif.dump_valid}, 64'd1);
    chk("pre_rst_idx", {61'd0, dif.dump_idx}, 64'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, dif.dump_valid}, 64'd0);
    chk("async_rst_idx", {61'd0, dif.dump_idx}, 64'd0);
    chk("async_rst_data", {32'd0, dif.dump_data}, 64'd0);
    chk("async_rst_rd", {32'd0, rd_data}, 64'd0);
    #2;
    rst = 1'b1;
    model_zero();
    for (int i = 0; i < 4; i++) count_cycle(1'b1, 1'b0, 1'b0, 4'b0100);
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    read_chk(0);
    read_chk(4);

    // 8-bit counters over 300 cycles: saturating and wrapping
    en8 = 1'b1;
    repeat (300) step();
    en8 = 1'b0;
    rd_idx8 = 3'd0;
    step();
    chk("sat_cycles", {56'd0, rd_s}, 64'hFF);
    chk("wrap_cycles", {56'd0, rd_w}, 64'h2C);
    chk("sat_ovf", {58'd0, ovf_s}, 64'h01);
    chk("wrap_ovf", {58'd0, ovf_w}, 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
